// File: rtl/multicycle_control_unit.sv
// Multi-cycle control unit: sequences each instruction through FETCH/DECODE/EXEC/MEM/WB
// and drives the datapath strobes with ready/valid handshakes to instruction and data memory.
//
// state  | meaning
// FETCH  | instr_req high; wait for instr_valid, latch opcode
// DECODE | alu_control / reg addresses valid; jump/branch asserted
// EXEC   | one cycle; route by class, finish BR/J/ILL
// MEM    | hold mem_ren or mem_wen until mem_ready
// WB     | rf_wen + pc_update for one cycle
module multicycle_control_unit #(
  parameter int   RADDR_W      = 2,
  parameter logic RESET_RF_WEN = 1'b0,
  localparam int  INSTR_W      = 4 + 2*RADDR_W
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               instr_valid,
  input  logic [INSTR_W-1:0] instruction,
  input  logic               mem_ready,
  output logic               instr_req,
  output logic [3:0]         alu_control,
  output logic [RADDR_W-1:0] reg_addr1,
  output logic [RADDR_W-1:0] reg_addr2,
  output logic               jump,
  output logic               branch,
  output logic               mem_ren,
  output logic               mem_wen,
  output logic               rf_wen,
  output logic               pc_update,
  output logic               illegal,
  output logic               busy
);

  typedef enum logic [2:0] {S_FETCH, S_DECODE, S_EXEC, S_MEM, S_WB} state_t;
  typedef enum logic [2:0] {C_ALU, C_LD, C_ST, C_BR, C_J, C_JL, C_ILL} cls_t;

  state_t     state;
  logic [3:0] ir_op;
  cls_t       ir_cls;
  cls_t       in_cls;
  logic       pc_update_q;

  function automatic logic [3:0] dec_alu(input logic [3:0] op);
    case (op)
      4'b0110, 4'b0111, 4'b1000, 4'b1001: dec_alu = 4'b0000;
      4'b1010:                            dec_alu = 4'b0001;
      default:                            dec_alu = op;
    endcase
  endfunction

  function automatic cls_t dec_cls(input logic [3:0] op);
    case (op)
      4'b0100:          dec_cls = C_LD;
      4'b0101:          dec_cls = C_ST;
      4'b0110, 4'b0111: dec_cls = C_ILL;
      4'b1010, 4'b1011: dec_cls = C_BR;
      4'b1110:          dec_cls = C_J;
      4'b1111:          dec_cls = C_JL;
      default:          dec_cls = C_ALU;
    endcase
  endfunction

  assign ir_cls = dec_cls(ir_op);
  assign in_cls = dec_cls(instruction[INSTR_W-1 -: 4]);

  // A store finishes in the very cycle memory acknowledges, so its PC pulse cannot be registered.
  assign pc_update = pc_update_q | ((state == S_MEM) && (ir_cls == C_ST) && mem_ready);

  always_ff @(posedge clk) begin
    if (reset) begin
      state       <= S_FETCH;
      ir_op       <= '0;
      alu_control <= '0;
      reg_addr1   <= '0;
      reg_addr2   <= '0;
      jump        <= 1'b0;
      branch      <= 1'b0;
      mem_ren     <= 1'b0;
      mem_wen     <= 1'b0;
      rf_wen      <= RESET_RF_WEN;
      pc_update_q <= 1'b0;
      illegal     <= 1'b0;
      busy        <= 1'b0;
      instr_req   <= 1'b0;
    end else begin
      rf_wen      <= 1'b0;
      pc_update_q <= 1'b0;
      case (state)
        S_FETCH: begin
          if (instr_valid && instr_req) begin
            ir_op       <= instruction[INSTR_W-1 -: 4];
            alu_control <= dec_alu(instruction[INSTR_W-1 -: 4]);
            reg_addr1   <= instruction[2*RADDR_W-1 -: RADDR_W];
            reg_addr2   <= instruction[RADDR_W-1:0];
            jump        <= (in_cls == C_J) || (in_cls == C_JL);
            branch      <= (in_cls == C_BR);
            instr_req   <= 1'b0;
            busy        <= 1'b1;
            state       <= S_DECODE;
          end else begin
            instr_req <= 1'b1;
          end
        end
        S_DECODE: begin
          state <= S_EXEC;
          if (ir_cls == C_BR || ir_cls == C_J || ir_cls == C_ILL)
            pc_update_q <= 1'b1;
          if (ir_cls == C_ILL)
            illegal <= 1'b1;
        end
        S_EXEC: begin
          case (ir_cls)
            C_ALU, C_JL: begin
              rf_wen      <= 1'b1;
              pc_update_q <= 1'b1;
              state       <= S_WB;
            end
            C_LD: begin
              mem_ren <= 1'b1;
              state   <= S_MEM;
            end
            C_ST: begin
              mem_wen <= 1'b1;
              state   <= S_MEM;
            end
            default: begin
              jump      <= 1'b0;
              branch    <= 1'b0;
              busy      <= 1'b0;
              instr_req <= 1'b1;
              state     <= S_FETCH;
            end
          endcase
        end
        S_MEM: begin
          if (mem_ready) begin
            mem_ren <= 1'b0;
            mem_wen <= 1'b0;
            if (ir_cls == C_LD) begin
              rf_wen      <= 1'b1;
              pc_update_q <= 1'b1;
              state       <= S_WB;
            end else begin
              busy      <= 1'b0;
              instr_req <= 1'b1;
              state     <= S_FETCH;
            end
          end
        end
        S_WB: begin
          jump      <= 1'b0;
          branch    <= 1'b0;
          busy      <= 1'b0;
          instr_req <= 1'b1;
          state     <= S_FETCH;
        end
        default: state <= S_FETCH;
      endcase
    end
  end

endmodule
